// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial D = A - B - Bin, LSB first, start/busy/done handshake.
//            Define SERIAL_SUBTRACTOR_OVF_EN for two's-complement overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf
);

  localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_d_sh;
  logic               r_borrow;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_d;
  logic               r_bout;

  logic               w_a0;
  logic               w_b0;
  logic               w_d;
  logic               w_borrow_nxt;
  logic [WIDTH-1:0]   w_d_sh_nxt;
  logic               w_last;

  // Single full-subtractor cell operating on the current LSBs
  assign w_a0         = r_a_sh[0];
  assign w_b0         = r_b_sh[0];
  assign w_d          = w_a0 ^ w_b0 ^ r_borrow;
  assign w_borrow_nxt = (~w_a0 & w_b0) | (~w_a0 & r_borrow) | (w_b0 & r_borrow);
  assign w_d_sh_nxt   = {w_d, r_d_sh[WIDTH-1:1]};
  assign w_last       = (r_state == c_st_run) && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_borrow <= Bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= c_st_run;
          end
        end
        c_st_run: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_d_sh   <= w_d_sh_nxt;
          r_borrow <= w_borrow_nxt;
          r_cnt    <= r_cnt + 1'b1;
          // Results publish only here, so D/Bout hold the prior value during RUN
          if (w_last) begin
            r_d     <= w_d_sh_nxt;
            r_bout  <= w_borrow_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_st_done;
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bout = r_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_msb_borrow;
  logic r_ovf;

  // Overflow iff the borrow into the sign bit differs from the borrow out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msb_borrow <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (r_state == c_st_run) begin
      if (r_cnt == c_last - 1'b1) begin
        r_msb_borrow <= w_borrow_nxt;
      end
      if (w_last) begin
        r_ovf <= r_msb_borrow ^ w_borrow_nxt;
      end
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH = 9).
`default_nettype none

module tb_serial_subtractor;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam logic c_ovf_en = 1'b1;
`else
  localparam logic c_ovf_en = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] A;
  logic [8:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [8:0] D;
  logic       Bout;
  logic       ovf;

  int pass_cnt;
  int chk_cnt;

  serial_subtractor #(.WIDTH(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; lat = number of edges after the accept edge until done is seen
  task automatic do_op(input logic [8:0] a, input logic [8:0] b, input logic bin,
                       output int lat);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [8:0] a, input logic [8:0] b,
                              input logic bin, input logic [8:0] exp_d,
                              input logic exp_bout, input logic exp_ovf_raw);
    int lat;
    logic exp_ovf;
    exp_ovf = exp_ovf_raw & c_ovf_en;
    do_op(a, b, bin, lat);
    chk_cnt++;
    if (lat !== 9) $display("FAIL %s latency: got %0d want 9", name, lat);
    else pass_cnt++;
    chk_cnt++;
    if ({D, Bout, ovf} !== {exp_d, exp_bout, exp_ovf})
      $display("FAIL %s result: got D=%h Bout=%b ovf=%b want D=%h Bout=%b ovf=%b",
               name, D, Bout, ovf, exp_d, exp_bout, exp_ovf);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'($urandom);
    A = 9'($urandom); B = 9'($urandom); Bin = 1'($urandom);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, done, D, Bout, ovf} !== 13'd0)
      $display("FAIL reset_hold: got busy=%b done=%b D=%h Bout=%b ovf=%b want all 0",
               busy, done, D, Bout, ovf);
    else pass_cnt++;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if ({busy, done, D, Bout, ovf} !== 13'd0)
      $display("FAIL reset_release: got busy=%b done=%b D=%h Bout=%b ovf=%b want all 0",
               busy, done, D, Bout, ovf);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int k;
    logic seen_bad;
    logic timed_out;
    @(negedge clk);
    A = 9'd300; B = 9'd45; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
    else pass_cnt++;
    seen_bad = 1'b0;
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (D !== 9'd0 || done !== 1'b0 || busy !== 1'b1) seen_bad = 1'b1;
    end
    chk_cnt++;
    if (seen_bad) $display("FAIL basic_run_hold: got D/done/busy disturbed want D=0 done=0 busy=1");
    else pass_cnt++;
    @(negedge clk);
    timed_out = (done !== 1'b1);
    chk_cnt++;
    if (timed_out || busy !== 1'b0)
      $display("FAIL basic_done: got done=%b busy=%b want done=1 busy=0", done, busy);
    else pass_cnt++;
    chk_cnt++;
    if ({D, Bout, ovf} !== {9'd255, 1'b0, 1'b0})
      $display("FAIL basic_result: got D=%0d Bout=%b ovf=%b want D=255 Bout=0 ovf=0", D, Bout, ovf);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || D !== 9'd255)
      $display("FAIL basic_done_pulse: got done=%b D=%0d want done=0 D=255", done, D);
    else pass_cnt++;
  endtask

  task automatic test_borrow();
    check_result("sub_5_6",      9'd5,    9'd6,    1'b0, 9'h1FF, 1'b1, 1'b0);
    check_result("sub_0_0_bin",  9'd0,    9'd0,    1'b1, 9'h1FF, 1'b1, 1'b0);
    check_result("sub_0ff_100",  9'h0FF,  9'h100,  1'b0, 9'h1FF, 1'b1, 1'b1);
    check_result("sub_100_0ff",  9'h100,  9'h0FF,  1'b0, 9'h001, 1'b0, 1'b1);
    check_result("sub_1ff_0_bin",9'h1FF,  9'h000,  1'b1, 9'h1FE, 1'b0, 1'b0);
    check_result("sub_0aa_155",  9'h0AA,  9'h155,  1'b1, 9'h154, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic bad_done;
    logic bad_busy;
    @(negedge clk);
    A = 9'd300; B = 9'd45; Bin = 1'b0; start = 1'b1;
    bad_done = 1'b0;
    bad_busy = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      if (done !== ((k == 9) || (k == 20))) bad_done = 1'b1;
      if (busy !== ((k <= 8) || (k >= 11 && k <= 19))) bad_busy = 1'b1;
      if (k == 9) begin
        chk_cnt++;
        if (D !== 9'd255) $display("FAIL b2b_first: got D=%0d want 255", D);
        else pass_cnt++;
      end
      if (k == 20) begin
        chk_cnt++;
        if (D !== 9'd10 || Bout !== 1'b0) $display("FAIL b2b_second: got D=%0d Bout=%b want D=10 Bout=0", D, Bout);
        else pass_cnt++;
      end
      A = 9'(10 + k);
      B = 9'(k);
      if (k == 12) start = 1'b0;
    end
    chk_cnt++;
    if (bad_done) $display("FAIL b2b_done_timing: got done outside cycles 9/20 want only 9 and 20");
    else pass_cnt++;
    chk_cnt++;
    if (bad_busy) $display("FAIL b2b_busy_timing: got busy pattern wrong want 0..8 and 11..19");
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    @(negedge clk);
    A = 9'd100; B = 9'd1; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy, done, D, Bout, ovf} !== 13'd0)
      $display("FAIL midrun_reset: got busy=%b done=%b D=%h Bout=%b ovf=%b want all 0",
               busy, done, D, Bout, ovf);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    chk_cnt++;
    if (saw_done) $display("FAIL midrun_no_done: got done/busy after reset want 0");
    else pass_cnt++;
    check_result("midrun_fresh", 9'd100, 9'd1, 1'b0, 9'd99, 1'b0, 1'b0);
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
